// File: rtl/scrambler_if.sv
// AXI-stream style beat bundle: data, rate code, frame end and handshake.
interface scrambler_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] tdata;
    logic [3:0]       tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    // Handshake: a beat transfers on a rising clock edge where tvalid and
    // tready are both high. The master holds tdata/tuser/tlast stable while
    // tvalid is high and tready is low, and never withdraws tvalid before
    // the transfer.
    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/scrambler.sv
// 802.11a PPDU scrambler: the SIGNAL beat passes through, DATA beats are
// XORed with the x^7+x^4+1 sequence and the tail bits of the final beat are
// cleared. A single output register gives one cycle of latency.
module scrambler #(
    parameter int         WIDTH        = 24,
    parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [6:0]   seed_i,
    input  logic [4:0]   tail_pos_i,
    scrambler_if.slave   s_axis,
    scrambler_if.master  m_axis,
    output logic         state_dbg
);

    typedef enum logic {
        ST_SIGNAL = 1'b0,
        ST_DATA   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [6:0]       lfsr;
    logic [6:0]       lfsr_next;
    logic [6:0]       lfsr_walk;
    logic [WIDTH-1:0] scrambled;
    logic [WIDTH-1:0] tail_mask;
    logic [WIDTH-1:0] data_next;
    logic             accept;

    // The output register can take a new beat when it is empty or draining.
    assign s_axis.tready = !m_axis.tvalid || m_axis.tready;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign state_dbg     = state;

    // Run the LFSR WIDTH steps in time order (bit 0 first) over the beat.
    always_comb begin
        lfsr_walk = lfsr;
        scrambled = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scrambled[i] = s_axis.tdata[i] ^ lfsr_walk[6] ^ lfsr_walk[3];
            lfsr_walk    = {lfsr_walk[5:0], lfsr_walk[6] ^ lfsr_walk[3]};
        end
    end

    // Mark the six tail positions; positions past the top bit simply drop out.
    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i >= int'(tail_pos_i)) && (i <= int'(tail_pos_i) + 5)) begin
                tail_mask[i] = 1'b1;
            end
        end
    end

    // Next-state, next-LFSR and next output data for an accepted beat.
    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        data_next  = s_axis.tdata;
        if (accept) begin
            case (state)
                ST_SIGNAL: begin
                    lfsr_next  = (seed_i == 7'd0) ? DEFAULT_SEED : seed_i;
                    state_next = s_axis.tlast ? ST_SIGNAL : ST_DATA;
                end
                ST_DATA: begin
                    lfsr_next = lfsr_walk;
                    if (s_axis.tlast) begin
                        data_next  = scrambled & ~tail_mask;
                        state_next = ST_SIGNAL;
                    end else begin
                        data_next = scrambled;
                    end
                end
                default: begin
                    state_next = ST_SIGNAL;
                end
            endcase
        end
    end

    // Frame context registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_SIGNAL;
            lfsr  <= 7'd0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
        end
    end

    // Output register: load on accept, empty after a transfer with no refill.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 4'd0;
            m_axis.tlast  <= 1'b0;
        end else if (accept) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tdata  <= data_next;
            m_axis.tuser  <= s_axis.tuser;
            m_axis.tlast  <= s_axis.tlast;
        end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// Self-checking bench for the 802.11a scrambler: directed frames, stalls,
// reset mid-frame and randomised back-pressure against a sequence model.
module tb_scrambler;

    logic       aclk;
    logic       areset;
    logic [6:0] seed;
    logic [4:0] tail_pos;
    logic       state_dbg;

    scrambler_if #(.WIDTH(24)) s_if ();
    scrambler_if #(.WIDTH(24)) m_if ();

    scrambler #(.WIDTH(24), .DEFAULT_SEED(7'b1011101)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .seed_i     (seed),
        .tail_pos_i (tail_pos),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [28:0] exp_q[$];
    int          checks;
    int          failures;
    logic        rnd_ready_en;

    // Reference model: frame position into the 127-bit sequence.
    logic        model_in_data;
    int          model_pos;
    bit          seq[127];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sequence from the recurrence x[k] = x[k-7] ^ x[k-4], seeded so that
    // the first seven history bits are the seed (bit 6 oldest).
    function automatic void build_seq(input logic [6:0] s);
        bit xs[134];
        for (int j = 0; j < 7; j++) xs[j] = s[6-j];
        for (int k = 0; k < 127; k++) begin
            xs[k+7] = xs[k] ^ xs[k+3];
            seq[k]  = xs[k+7];
        end
    endfunction

    function automatic logic [23:0] model_beat(input logic [23:0] d, input logic l,
                                               input logic [6:0] sd, input logic [4:0] tp);
        logic [23:0] r;
        r = d;
        if (!model_in_data) begin
            build_seq((sd == 7'd0) ? 7'b1011101 : sd);
            model_pos     = 0;
            model_in_data = !l;
        end else begin
            for (int i = 0; i < 24; i++) r[i] = d[i] ^ seq[(model_pos + i) % 127];
            if (l) begin
                for (int i = 0; i < 24; i++)
                    if (i >= int'(tp) && i < int'(tp) + 6) r[i] = 1'b0;
                model_in_data = 1'b0;
            end
            model_pos += 24;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [23:0] d, input logic [3:0] u, input logic l,
                             input logic [6:0] sd, input logic [4:0] tp,
                             input logic use_fixed, input logic [23:0] fixed);
        logic [23:0] e;
        int          waited;
        bit          done;
        waited       = 0;
        done         = 0;
        s_if.tdata   = d;
        s_if.tuser   = u;
        s_if.tlast   = l;
        s_if.tvalid  = 1'b1;
        seed         = sd;
        tail_pos     = tp;
        while (!done) begin
            if (rnd_ready_en) m_if.tready = 1'($urandom_range(0, 1));
            #1;
            if (s_if.tready) begin
                e = model_beat(d, l, sd, tp);
                if (use_fixed) e = fixed;
                exp_q.push_back({l, u, e});
                done = 1;
            end
            @(posedge aclk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_if.tready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            tick(1);
            t++;
        end
        tick(1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    // Compares each transferred output beat against the oldest expectation.
    always @(negedge aclk) begin
        if (!areset && m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                check("tdata", 32'(m_if.tdata), 32'(e[23:0]));
                check("tuser", 32'(m_if.tuser), 32'(e[27:24]));
                check("tlast", 32'(m_if.tlast), 32'(e[28]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks        = 0;
        failures      = 0;
        rnd_ready_en  = 1'b0;
        model_in_data = 1'b0;
        model_pos     = 0;
        areset        = 1'b1;
        seed          = 7'd0;
        tail_pos      = 5'd0;
        s_if.tdata    = '0;
        s_if.tuser    = 4'd0;
        s_if.tlast    = 1'b0;
        s_if.tvalid   = 1'b0;
        m_if.tready   = 1'b1;

        // Reset state
        tick(2);
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_tuser", 32'(m_if.tuser), 32'd0);
        check("rst_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        areset = 1'b0;
        #1;
        check("rst_s_tready", 32'(s_if.tready), 32'd1);

        // Known vector, full throughput
        send_beat(24'h000c8d, 4'hB, 1'b0, 7'h7F, 5'd0, 1'b1, 24'h000c8d);
        check("latency_valid", 32'(m_if.tvalid), 32'd1);
        send_beat(24'h000000, 4'hB, 1'b0, 7'h7F, 5'd0, 1'b1, 24'h934F70);
        send_beat(24'h000000, 4'hB, 1'b1, 7'h7F, 5'd20, 1'b0, 24'h0);
        drain();

        // Same vector with back-pressure after the SIGNAL beat
        send_beat(24'h000c8d, 4'h3, 1'b0, 7'h7F, 5'd0, 1'b1, 24'h000c8d);
        m_if.tready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_s_tready", 32'(s_if.tready), 32'd0);
            check("stall_valid", 32'(m_if.tvalid), 32'd1);
            check("stall_tdata", 32'(m_if.tdata), 32'h000c8d);
            tick(1);
        end
        m_if.tready = 1'b1;
        send_beat(24'h000000, 4'h3, 1'b0, 7'h7F, 5'd0, 1'b1, 24'h934F70);
        send_beat(24'h000000, 4'h3, 1'b1, 7'h7F, 5'd18, 1'b0, 24'h0);
        drain();

        // Long all-zero frame (wraps the 127-bit sequence), tail at 10, then
        // a SIGNAL beat straight after with seed 0, ending with tail at 21
        send_beat(24'h00abcd, 4'h1, 1'b0, 7'h7F, 5'd0, 1'b0, 24'h0);
        for (int b = 0; b < 6; b++)
            send_beat(24'h000000, 4'h1, 1'b0, 7'h7F, 5'd0, 1'b0, 24'h0);
        send_beat(24'h000000, 4'h1, 1'b1, 7'h7F, 5'd10, 1'b0, 24'h0);
        send_beat(24'h123456, 4'h5, 1'b0, 7'h00, 5'd0, 1'b0, 24'h0);
        send_beat(24'h000000, 4'h5, 1'b0, 7'h00, 5'd0, 1'b0, 24'h0);
        send_beat(24'h000000, 4'h5, 1'b1, 7'h00, 5'd21, 1'b0, 24'h0);
        drain();

        // Reset mid-frame with a held output beat
        m_if.tready = 1'b0;
        send_beat(24'hABCDEF, 4'h7, 1'b0, 7'h2A, 5'd0, 1'b0, 24'h0);
        areset = 1'b1;
        tick(1);
        areset = 1'b0;
        exp_q.delete();
        model_in_data = 1'b0;
        #1;
        check("rst_mid_tvalid", 32'(m_if.tvalid), 32'd0);
        m_if.tready = 1'b1;
        #1;
        check("rst_mid_s_tready", 32'(s_if.tready), 32'd1);
        send_beat(24'h5A5A5A, 4'h9, 1'b0, 7'h11, 5'd0, 1'b0, 24'h0);
        send_beat(24'hFFFFFF, 4'h9, 1'b1, 7'h11, 5'd4, 1'b0, 24'h0);
        drain();

        // Random frames with random back-pressure
        rnd_ready_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int          nb;
            logic [6:0]  sd;
            logic [3:0]  u;
            sd = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            u  = 4'($urandom_range(0, 15));
            nb = $urandom_range(0, 4);
            send_beat(24'($urandom()), u, (nb == 0), sd, 5'd0, 1'b0, 24'h0);
            for (int b = 0; b < nb; b++)
                send_beat(24'($urandom()), u, (b == nb - 1), sd,
                          5'($urandom_range(0, 23)), 1'b0, 24'h0);
        end
        rnd_ready_en = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
